// File: rtl/flags_stack.sv
// flags_stack: status-flag register (C, Z, ...) with masked updates and a
// LIFO save stack for CALL/interrupt entry and RET.
// Optional build macro FLAGS_STACK_ERR_EN enables the sticky err flag for
// push-when-full / pop-when-empty; without it err is tied low.
module flags_stack #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] flags_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             push,
  input  logic             pop,
  input  logic             clear_err,
  output logic [WIDTH-1:0] flags_out,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  // Entries are never reset; only [0, count) hold meaningful data.
  logic [WIDTH-1:0] stack [DEPTH];

  logic          do_push, do_pop, bad_op;
  logic [CW-1:0] top;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // push+pop together cancel out; illegal operations are dropped.
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign bad_op  = (push & ~pop & full) | (pop & ~push & empty);
  assign top     = count - CW'(1);

  // Current flags and stack occupancy; a legal pop overrides any update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_out <= '0;
      count     <= '0;
    end else begin
      if (do_pop)
        flags_out <= stack[top[AW-1:0]];
      else if (enable)
        flags_out <= (flags_out & ~mask) | (flags_in & mask);
      if (do_push)
        count <= count + CW'(1);
      else if (do_pop)
        count <= count - CW'(1);
    end
  end

  // Save the pre-edge flags into the next free slot; suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!reset && do_push)
      stack[count[AW-1:0]] <= flags_out;
  end

`ifdef FLAGS_STACK_ERR_EN
  // Sticky error: a new error in the same cycle as clear_err wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (bad_op)
      err <= 1'b1;
    else if (clear_err)
      err <= 1'b0;
  end
`else
  logic unused_err_inputs;
  assign unused_err_inputs = clear_err | bad_op;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_flags_stack.sv
// Self-checking bench for flags_stack (WIDTH=2, DEPTH=4): directed vector
// table, hand-written reset sequences, then random traffic checked against
// a queue-based reference model.
module tb_flags_stack;

`ifdef FLAGS_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] flags_in = '0;
  logic [1:0] mask = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       clear_err = 1'b0;
  logic [1:0] flags_out;
  logic [2:0] count;
  logic       full, empty, err;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [1:0] m_flags;
  logic [1:0] m_stk[$];
  logic       m_err;

  flags_stack #(.WIDTH(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flags_in(flags_in),
    .mask(mask), .push(push), .pop(pop), .clear_err(clear_err),
    .flags_out(flags_out), .count(count), .full(full), .empty(empty),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] fi;
    logic [1:0] m;
    logic       pu;
    logic       po;
    logic       ce;
    logic [1:0] ef;
    logic [2:0] ec;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ef, input logic [2:0] ec,
                         input logic ee);
    chk({tag, " flags_out"}, 32'(flags_out), 32'(ef));
    chk({tag, " count"},     32'(count),     32'(ec));
    chk({tag, " full"},      32'(full),      32'(ec == 3'd4));
    chk({tag, " empty"},     32'(empty),     32'(ec == 3'd0));
    chk({tag, " err"},       32'(err),       32'(ee));
  endtask

  function automatic void model_reset();
    m_flags = '0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  // Next state from the rules: queue is the stack, back is the top.
  function automatic void model_step(input logic en, input logic [1:0] fi, input logic [1:0] m,
                                     input logic pu, input logic po, input logic ce);
    logic [1:0] nf;
    bit only_push, only_pop, bad;
    only_push = pu && !po;
    only_pop  = po && !pu;
    bad = (only_push && m_stk.size() == 4) || (only_pop && m_stk.size() == 0);
    nf = m_flags;
    if (only_pop && m_stk.size() > 0) nf = m_stk.pop_back();
    else if (en) nf = (m_flags & ~m) | (fi & m);
    if (only_push && m_stk.size() < 4) m_stk.push_back(m_flags);
    if (ERR_EN) begin
      if (bad) m_err = 1'b1;
      else if (ce) m_err = 1'b0;
    end
    m_flags = nf;
  endfunction

  task automatic step(input logic en, input logic [1:0] fi, input logic [1:0] m,
                      input logic pu, input logic po, input logic ce);
    enable = en; flags_in = fi; mask = m; push = pu; pop = po; clear_err = ce;
    @(posedge clk);
    model_step(en, fi, m, pu, po, ce);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_flags, 3'(m_stk.size()), m_err);
  endtask

  initial begin
    //        en fi     m      pu po ce  ef     ec ee
    tbl.push_back('{1, 2'b10, 2'b11, 0, 0, 0, 2'b10, 0, 0}); // full-mask load
    tbl.push_back('{1, 2'b01, 2'b01, 0, 0, 0, 2'b11, 0, 0}); // partial mask
    tbl.push_back('{1, 2'b01, 2'b11, 0, 0, 0, 2'b01, 0, 0});
    tbl.push_back('{1, 2'b10, 2'b11, 1, 0, 0, 2'b10, 1, 0}); // push+update
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b01, 0, 0}); // restore 01
    tbl.push_back('{1, 2'b00, 2'b11, 0, 0, 0, 2'b00, 0, 0});
    tbl.push_back('{1, 2'b01, 2'b11, 1, 0, 0, 2'b01, 1, 0}); // saves 00
    tbl.push_back('{1, 2'b10, 2'b11, 1, 0, 0, 2'b10, 2, 0}); // saves 01
    tbl.push_back('{1, 2'b11, 2'b11, 1, 0, 0, 2'b11, 3, 0}); // saves 10
    tbl.push_back('{0, 2'b00, 2'b00, 1, 0, 0, 2'b11, 4, 0}); // saves 11, full
    tbl.push_back('{0, 2'b00, 2'b00, 1, 0, 0, 2'b11, 4, 1}); // push on full
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b11, 3, 1});
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b10, 2, 1});
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b01, 1, 1});
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 1});
    tbl.push_back('{0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 0}); // clear_err
    tbl.push_back('{1, 2'b11, 2'b11, 0, 1, 0, 2'b11, 0, 1}); // pop on empty
    tbl.push_back('{0, 2'b00, 2'b00, 0, 0, 1, 2'b11, 0, 0});
    tbl.push_back('{0, 2'b00, 2'b00, 1, 0, 0, 2'b11, 1, 0}); // saves 11
    tbl.push_back('{1, 2'b00, 2'b11, 0, 0, 0, 2'b00, 1, 0});
    tbl.push_back('{1, 2'b10, 2'b11, 0, 1, 0, 2'b11, 0, 0}); // pop beats enable
    tbl.push_back('{1, 2'b01, 2'b11, 1, 0, 0, 2'b01, 1, 0}); // saves 11
    tbl.push_back('{1, 2'b10, 2'b11, 1, 0, 0, 2'b10, 2, 0}); // saves 01
    tbl.push_back('{1, 2'b00, 2'b01, 1, 1, 0, 2'b10, 2, 0}); // push+pop: no stack op
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b01, 1, 0}); // entries intact
    tbl.push_back('{0, 2'b00, 2'b00, 0, 1, 0, 2'b11, 0, 0});

    // reset state, held across an edge with a push requested
    push = 1'b1;
    #1 chk_all("reset", 2'b00, 3'd0, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_edge", 2'b00, 3'd0, 1'b0);
    push = 1'b0;
    #2 reset = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].fi, tbl[i].m, tbl[i].pu, tbl[i].po, tbl[i].ce);
      chk_all($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ec, ERR_EN ? tbl[i].ee : 1'b0);
    end

    // clear_err together with a new error keeps err set
    step(0, 2'b00, 2'b00, 0, 1, 0);
    step(0, 2'b00, 2'b00, 0, 1, 1);
    chk_all("clr_vs_err", 2'b11, 3'd0, ERR_EN);

    // asynchronous reset between edges, with stack and err non-zero
    step(1, 2'b01, 2'b11, 1, 0, 0);
    step(0, 2'b00, 2'b00, 1, 0, 0);
    step(1, 2'b10, 2'b10, 0, 1, 0);
    chk_model("pre_reset");
    #3 reset = 1'b1;
    #1 chk_all("async_reset", 2'b00, 3'd0, 1'b0);
    push = 1'b1; enable = 1'b1; flags_in = 2'b11; mask = 2'b11;
    @(posedge clk); #1;
    chk_all("reset_hold", 2'b00, 3'd0, 1'b0);
    push = 1'b0; enable = 1'b0;
    #2 reset = 1'b0;
    model_reset();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic en, pu, po, ce;
      logic [1:0] fi, m;
      en = ($urandom_range(0, 1) == 1);
      fi = 2'($urandom);
      m  = 2'($urandom);
      pu = ($urandom_range(0, 99) < 35);
      po = ($urandom_range(0, 99) < 35);
      ce = ($urandom_range(0, 99) < 10);
      step(en, fi, m, pu, po, ce);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flags_stack.md
FLAGS_STACK -- requirements
Module: flags_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of status flags (bit0 = C, bit1 = Z).
REQ-002 SHALL have parameter DEPTH, default 4, number of save-stack entries (DEPTH >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  flag-update strobe.
REQ-006 SHALL have port flags_in  input  WIDTH  new flag values (ALU C, Z, ...).
REQ-007 SHALL have port mask  input  WIDTH  per-bit update enable, used when enable=1.
REQ-008 SHALL have port push  input  1  save current flags onto the stack (CALL/interrupt entry).
REQ-009 SHALL have port pop  input  1  restore flags from the stack top (RET).
REQ-010 SHALL have port clear_err  input  1  clears err.
REQ-011 SHALL have port flags_out  output  WIDTH  registered current flags.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  occupied stack entries.
REQ-013 SHALL have ports full and empty  output  1 each  count==DEPTH, count==0.
REQ-014 SHALL have port err  output  1  sticky illegal-stack-operation flag.

Function
REQ-015 SHALL, when enable=1 and no pop takes effect, load flags_out[i] <= flags_in[i] for each i with mask[i]=1 and hold bits with mask[i]=0.
REQ-016 SHALL hold flags_out when enable=0 and no pop takes effect.
REQ-017 SHALL make every update visible on flags_out one cycle after the sampling edge; no combinational path from inputs to flags_out.
REQ-018 SHALL, on push with count<DEPTH, write the pre-edge flags_out to entry[count] and increment count.
REQ-019 SHALL, on push with enable=1 in the same cycle, save the pre-update value and still apply the masked update to flags_out.
REQ-020 SHALL, on pop with count>0, load flags_out <= entry[count-1] and decrement count; a simultaneous enable is ignored (pop wins).
REQ-021 SHALL treat push=1 and pop=1 in the same cycle as no stack operation; count and entries unchanged; enable applies per REQ-015.
REQ-022 SHALL ignore push when full (count, entries, flags_out unaffected by the push; enable still applies).
REQ-023 SHALL ignore pop when empty (flags_out unaffected by the pop; enable still applies).
REQ-024 SHALL derive full and empty combinationally from count.
REQ-025 SHALL not modify stack entries at or above count except by a legal push.

Reset
REQ-026 SHALL, on reset asserted, immediately set flags_out=0, count=0, err=0 regardless of clk.
REQ-027 SHALL give empty=1, full=0 during and after reset; entry contents need not be cleared.
REQ-028 SHALL abort any push/pop in the cycle reset is asserted; no partial stack state.

Configuration
REQ-029 SHALL implement err tracking only when macro FLAGS_STACK_ERR_EN is defined: err set on push-when-full or pop-when-empty, held until clear_err=1 or reset; clear_err and a new error in the same cycle leave err=1.
REQ-030 SHALL, without FLAGS_STACK_ERR_EN, tie err to 0 and ignore clear_err; REQ-022/REQ-023 behaviour unchanged.

Verification (WIDTH=2, DEPTH=4, FLAGS_STACK_ERR_EN defined)
REQ-031 SHALL cover: reset, enable=1 mask=2'b11 flags_in=2'b10 -> flags_out=2'b10 next cycle; then mask=2'b01 flags_in=2'b01 -> flags_out=2'b11.
REQ-032 SHALL cover: flags_out=2'b01, push with enable=1 mask=2'b11 flags_in=2'b10 -> entry0=2'b01, flags_out=2'b10, count=1; pop -> flags_out=2'b01, count=0, empty=1.
REQ-033 SHALL cover: push values 00,01,10,11 -> count=4, full=1; 5th push -> count=4, err=1; four pops -> 11,10,01,00 in order; clear_err -> err=0.
REQ-034 SHALL cover: pop when empty with enable=1 flags_in=2'b11 mask=2'b11 -> flags_out=2'b11, count=0, err=1; pop with enable at count=1 -> restored value, enable ignored.
REQ-035 SHALL cover: push and pop together at count=2 -> count=2, entries unchanged; reset asserted mid-cycle between edges -> flags_out=0, count=0, err=0 immediately.
REQ-036 SHALL cover: build without FLAGS_STACK_ERR_EN, push on full -> err stays 0, count stays 4.
